// File: rtl/text_blitter.sv
// text_blitter: expands 8x8 font glyphs into 16x16 pixel cells and streams them,
// one pixel per clock, into the framebuffer write port. Font RAM loads over ioctl.
module text_blitter #(
  parameter int unsigned SCREEN_WIDTH       = 640,
  parameter int unsigned SCREEN_CHAR_WIDTH  = 40,
  parameter int unsigned SCREEN_CHAR_HEIGHT = 25,
  parameter int unsigned FONT_NUM_CHARS     = 96,
  parameter int unsigned FONT_BMP_SIZE      = 768
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  ch_code,
  input  logic [5:0]  ch_col,
  input  logic [4:0]  ch_row,
  input  logic [7:0]  ch_fg,
  input  logic [7:0]  ch_bg,
  output logic        cpu_wr,
  output logic [31:0] cpu_addr,
  output logic [7:0]  cpu_data
);
  localparam int unsigned FONT_AW = 10;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned CNT_W   = 4;
  localparam logic [GLYPH_W-1:0] GLYPH_UNKNOWN = 7'd31;
  localparam logic [7:0]         CODE_FIRST    = 8'h20;
  localparam logic [CNT_W-1:0]   CNT_LAST      = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW} state_t;

  // Constant multiply as a shift-and-add chain.
  function automatic logic [31:0] mul_const(input logic [31:0] x, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_px, r_py, w_px_nxt, w_py_nxt, w_px_inc;
  logic [31:0]          r_line, w_line_nxt;
  logic [GLYPH_W-1:0]   r_glyph, w_glyph_in, w_glyph_rd;
  logic [7:0]           r_fg, r_bg;
  logic                 r_oor;
  logic                 r_font_vld;
  logic [7:0]           r_font_q;
  logic [7:0]           r_font_ram [FONT_BMP_SIZE];
  logic [FONT_AW-1:0]   w_rd_addr;
  logic                 w_capture, w_code_ok, w_oor_in, w_font_wr_ok;
  logic [31:0]          w_base_in;
  logic                 w_wr_nxt;
  logic [31:0]          w_addr_nxt;
  logic [7:0]           w_data_nxt;
  logic                 w_unused_addr;

  assign w_unused_addr = ^ioctl_addr[26:10];
  assign w_font_wr_ok  = 32'(ioctl_addr[9:0]) < FONT_BMP_SIZE;

  // Request decode straight from the inputs, used only on the handshake cycle.
  assign w_code_ok  = (ch_code >= CODE_FIRST) &&
                      (32'(ch_code) < 32'(CODE_FIRST) + FONT_NUM_CHARS);
  assign w_glyph_in = w_code_ok ? GLYPH_W'(ch_code - CODE_FIRST) : GLYPH_UNKNOWN;
  assign w_oor_in   = (32'(ch_col) >= SCREEN_CHAR_WIDTH) ||
                      (32'(ch_row) >= SCREEN_CHAR_HEIGHT);
  assign w_base_in  = mul_const(32'(ch_row), SCREEN_WIDTH * 16) + (32'(ch_col) << 4);
  assign w_px_inc   = r_px + 4'd1;

  // The font byte for the row about to be drawn is read on the edge entering FETCH.
  assign w_glyph_rd = (r_state == S_IDLE) ? w_glyph_in : r_glyph;
  assign w_rd_addr  = {w_glyph_rd, w_py_nxt[3:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_line_nxt  = r_line;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = cpu_addr;
    w_data_nxt  = cpu_data;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_px_nxt = '0;
        w_py_nxt = '0;
        if (ch_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_FETCH;
          w_line_nxt  = w_base_in;
        end
      end
      S_FETCH: begin
        if (!ioctl_wr) begin
          if (r_oor) begin
            w_state_nxt = S_IDLE;
          end else if (r_font_vld) begin
            w_state_nxt = S_DRAW;
            w_px_nxt    = '0;
            w_wr_nxt    = 1'b1;
            w_addr_nxt  = r_line;
            w_data_nxt  = r_font_q[7] ? r_fg : r_bg;
          end
        end
      end
      S_DRAW: begin
        if (!ioctl_wr) begin
          if (r_px != CNT_LAST) begin
            w_px_nxt   = w_px_inc;
            w_wr_nxt   = 1'b1;
            w_addr_nxt = r_line + 32'(w_px_inc);
            w_data_nxt = r_font_q[~w_px_inc[3:1]] ? r_fg : r_bg;
          end else if (r_py == CNT_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FETCH;
            w_py_nxt    = r_py + 4'd1;
            w_line_nxt  = r_line + SCREEN_WIDTH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_px       <= '0;
      r_py       <= '0;
      r_line     <= '0;
      r_font_vld <= 1'b0;
      ch_ready   <= 1'b1;
      cpu_wr     <= 1'b0;
      cpu_addr   <= '0;
      cpu_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_px       <= w_px_nxt;
      r_py       <= w_py_nxt;
      r_line     <= w_line_nxt;
      // Latched byte stays valid while ioctl holds the port, except for a
      // request captured during a font write, which still needs its read.
      if (!ioctl_wr)      r_font_vld <= 1'b1;
      else if (w_capture) r_font_vld <= 1'b0;
      ch_ready   <= (w_state_nxt == S_IDLE);
      cpu_wr     <= w_wr_nxt;
      cpu_addr   <= w_addr_nxt;
      cpu_data   <= w_data_nxt;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_capture) begin
      r_glyph <= w_glyph_in;
      r_fg    <= ch_fg;
      r_bg    <= ch_bg;
      r_oor   <= w_oor_in;
    end
  end

  // Single-port font RAM: ioctl writes take priority over glyph reads.
  always_ff @(posedge pclk) begin
    if (ioctl_wr) begin
      if (w_font_wr_ok) r_font_ram[ioctl_addr[9:0]] <= ioctl_dout;
    end else begin
      r_font_q <= r_font_ram[w_rd_addr];
    end
  end

endmodule
